// File: rtl/lock_door_actuator.sv
// Bolt motor sequencer downstream of the lock FSM: retract, timed hold-open,
// extend, with door-sensor interlocks and a door-ajar alarm.
module lock_door_actuator #(
   parameter int MOTOR_CYCLES = 4,
   parameter int HOLD_CYCLES  = 20,
   parameter int AJAR_CYCLES  = 50,
   parameter int CNT_W        = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       unlocked,
   input  logic       closer,
   input  logic       door_closed,
   output logic       bolt_retract,
   output logic       bolt_extend,
   output logic       locked,
   output logic       near_led,
   output logic       ajar_alarm,
   output logic [1:0] state_dbg
);

   typedef enum logic [1:0] {
      LOCKED  = 2'd0,
      OPENING = 2'd1,
      HOLD    = 2'd2,
      CLOSING = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] MOTOR_LOAD = CNT_W'(MOTOR_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] AJAR_MAX   = CNT_W'(AJAR_CYCLES);
   localparam logic [CNT_W-1:0] AJAR_LAST  = CNT_W'(AJAR_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic [CNT_W-1:0] ajar_cnt_reg, ajar_cnt_next;
   logic             ajar_alarm_reg, ajar_alarm_next;
   logic             unlocked_d_reg;
   logic             near_led_reg;
   logic             req;
   logic             hold_open;

   assign req       = unlocked & ~unlocked_d_reg;
   assign hold_open = (state_reg == HOLD) && !door_closed;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg      <= LOCKED;
         cnt_reg        <= '0;
         ajar_cnt_reg   <= '0;
         ajar_alarm_reg <= 1'b0;
         unlocked_d_reg <= 1'b0;
         near_led_reg   <= 1'b0;
      end else begin
         state_reg      <= state_next;
         cnt_reg        <= cnt_next;
         ajar_cnt_reg   <= ajar_cnt_next;
         ajar_alarm_reg <= ajar_alarm_next;
         unlocked_d_reg <= unlocked;
         near_led_reg   <= closer;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
         LOCKED: begin
            if (req) begin
               state_next = OPENING;
               cnt_next   = MOTOR_LOAD;
            end
         end
         OPENING: begin
            if (cnt_reg != '0) begin
               cnt_next = cnt_reg - CNT_ONE;
            end else begin
               state_next = HOLD;
               cnt_next   = HOLD_LOAD;
            end
         end
         HOLD: begin
            // An open door keeps restarting the hold timer.
            if (!door_closed) begin
               cnt_next = HOLD_LOAD;
            end else if (cnt_reg != '0) begin
               cnt_next = cnt_reg - CNT_ONE;
            end else begin
               state_next = CLOSING;
               cnt_next   = MOTOR_LOAD;
            end
         end
         CLOSING: begin
            // Never drive the bolt into an open door: back off fully instead.
            if (!door_closed) begin
               state_next = OPENING;
               cnt_next   = MOTOR_LOAD;
            end else if (cnt_reg != '0) begin
               cnt_next = cnt_reg - CNT_ONE;
            end else begin
               state_next = LOCKED;
            end
         end
         default: begin
            state_next = LOCKED;
            cnt_next   = '0;
         end
      endcase
   end

   always_comb begin
      ajar_cnt_next   = '0;
      ajar_alarm_next = 1'b0;
      if (hold_open) begin
         ajar_cnt_next   = (ajar_cnt_reg == AJAR_MAX) ? ajar_cnt_reg : ajar_cnt_reg + CNT_ONE;
         ajar_alarm_next = (ajar_cnt_reg == AJAR_LAST) || ajar_alarm_reg;
      end
   end

   assign bolt_retract = (state_reg == OPENING);
   assign bolt_extend  = (state_reg == CLOSING);
   assign locked       = (state_reg == LOCKED);
   assign near_led     = near_led_reg;
   assign ajar_alarm   = ajar_alarm_reg;
   assign state_dbg    = state_reg;

endmodule

// File: tb/tb_lock_door_actuator.sv
// Directed-vector bench for lock_door_actuator: each character of the stimulus
// strings is one clock cycle, with hand-computed expected state and alarm.
module tb_lock_door_actuator;

   logic       clk;
   logic       reset;
   logic       unlocked;
   logic       closer;
   logic       door_closed;
   logic       bolt_retract;
   logic       bolt_extend;
   logic       locked;
   logic       near_led;
   logic       ajar_alarm;
   logic [1:0] state_dbg;

   int err_cnt = 0;
   int chk_cnt = 0;

   lock_door_actuator #(
      .MOTOR_CYCLES(4),
      .HOLD_CYCLES (6),
      .AJAR_CYCLES (5),
      .CNT_W       (8)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .unlocked    (unlocked),
      .closer      (closer),
      .door_closed (door_closed),
      .bolt_retract(bolt_retract),
      .bolt_extend (bolt_extend),
      .locked      (locked),
      .near_led    (near_led),
      .ajar_alarm  (ajar_alarm),
      .state_dbg   (state_dbg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      chk_cnt++;
      if (got != exp) begin
         err_cnt++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic bit_at(input string s, input int i);
      byte c;
      if (i >= s.len()) return 1'b0;
      c = s[i];
      return (c == 8'h31);
   endfunction

   function automatic int digit_at(input string s, input int i);
      byte c;
      c = s[i];
      return int'(c) - 48;
   endfunction

   // One character per cycle: inputs are applied, the clock ticks, and the
   // registered outputs are compared 1 time unit after the edge.
   task automatic run_vec(input string tag, input string rs_s, input string un_s,
                          input string dr_s, input string cl_s,
                          input string st_s, input string al_s);
      int est;
      int eal;
      int enear;
      for (int i = 0; i < st_s.len(); i++) begin
         reset       = bit_at(rs_s, i);
         unlocked    = bit_at(un_s, i);
         door_closed = bit_at(dr_s, i);
         closer      = bit_at(cl_s, i);
         @(posedge clk);
         #1;
         est   = digit_at(st_s, i);
         eal   = digit_at(al_s, i);
         enear = (bit_at(rs_s, i) && bit_at(cl_s, i)) ? 1 : 0;
         $display("%s[%0d] state=%0d retract=%0d extend=%0d locked=%0d alarm=%0d near=%0d",
                  tag, i, state_dbg, bolt_retract, bolt_extend, locked, ajar_alarm, near_led);
         check($sformatf("%s[%0d] state_dbg", tag, i), int'(state_dbg), est);
         check($sformatf("%s[%0d] bolt_retract", tag, i), int'(bolt_retract), (est == 1) ? 1 : 0);
         check($sformatf("%s[%0d] bolt_extend", tag, i), int'(bolt_extend), (est == 3) ? 1 : 0);
         check($sformatf("%s[%0d] locked", tag, i), int'(locked), (est == 0) ? 1 : 0);
         check($sformatf("%s[%0d] ajar_alarm", tag, i), int'(ajar_alarm), eal);
         check($sformatf("%s[%0d] near_led", tag, i), int'(near_led), enear);
      end
   endtask

   initial begin
      reset       = 1'b0;
      unlocked    = 1'b0;
      closer      = 1'b0;
      door_closed = 1'b1;

      // Reset holds LOCKED and clears near_led even with closer high.
      run_vec("reset", "00", "00", "11", "11", "00", "00");

      // Basic unlock: 4 retract, 6 hold, 4 extend, then locked.
      run_vec("basic",
              "1111111111111111",
              "0111111111111111",
              "1111111111111111",
              "",
              "0111122222233330",
              "0000000000000000");

      // unlocked held high: no restart; a new edge starts one sequence; an
      // edge arriving as CLOSING returns to LOCKED is ignored.
      run_vec("retoggle",
              "11111111111111111111111",
              "11111011111111111110111",
              "11111111111111111111111",
              "",
              "00000011112222223333000",
              "00000000000000000000000");

      // Door open 8 cycles from HOLD cycle 2: alarm, timer reload.
      run_vec("ajar",
              "1111111111111111111111111",
              "0111111111111111111111111",
              "1111111000000001111111111",
              "",
              "0111122222222222222233330",
              "0000000000011110000000000");

      // Door opens during CLOSING cycle 2: full re-retract, full hold.
      run_vec("abort",
              "1111111111111111111111111111",
              "0111111111111111111111111111",
              "1111111111111011111111111111",
              "",
              "0111122222233111122222233330",
              "0000000000000000000000000000");

      // Reset mid-stroke, then a normal unlock.
      run_vec("midrst",
              "11101111111111111111",
              "01100111111111111111",
              "11111111111111111111",
              "",
              "01100111122222233330",
              "00000000000000000000");

      // closer pulses in OPENING and HOLD only affect near_led.
      run_vec("closer",
              "1111111111111111",
              "0111111111111111",
              "1111111111111111",
              "0101000101000000",
              "0111122222233330",
              "0000000000000000");

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/lock_door_actuator.md
Name: lock_door_actuator

Overview:
- Downstream stage of the digital lock FSM. Consumes its `unlocked` and `closer` outputs and drives the physical bolt motor, a door-ajar alarm and the status indicators.
- Sequences each unlock event through four steps: bolt retract, timed hold-open, bolt extend, back to locked.
- Includes door-sensor interlocks so the bolt never extends into an open door.

Parameters:
- MOTOR_CYCLES, 4: cycles the bolt motor is driven per retract or extend stroke (≥1).
- HOLD_CYCLES, 20: minimum cycles the door stays unlocked after retract completes (≥1).
- AJAR_CYCLES, 50: consecutive door-open cycles in HOLD before the alarm asserts (≥1).
- CNT_W, 8: width of the internal counters. Every parameter must be ≤ 2^CNT_W − 1.

Ports:
- clk, input, 1: single system clock; all logic acts on the rising edge.
- reset, input, 1: synchronous, active-low reset.
- unlocked, input, 1: level from the lock FSM; a rising edge is an unlock request.
- closer, input, 1: "one step from code" hint from the lock FSM.
- door_closed, input, 1: door sensor; 1 = door shut. Already synchronised upstream.
- bolt_retract, output, 1: motor drive, retract direction.
- bolt_extend, output, 1: motor drive, extend direction.
- locked, output, 1: 1 when the bolt is fully extended (state LOCKED).
- near_led, output, 1: registered copy of closer.
- ajar_alarm, output, 1: door held open too long.
- state_dbg, output, 2: current state encoding.

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=LOCKED, all counters 0, unlocked_d=0.
  - locked=1; bolt_retract=0, bolt_extend=0, near_led=0, ajar_alarm=0.
  - Reset wins over every other event, including mid-stroke. The motor stops at the next edge.
- Edge detect: unlocked_d <= unlocked every cycle; unlock request req = unlocked & ~unlocked_d.
- near_led <= closer every cycle (1-cycle latency), independent of state.
- Outputs are Moore, decoded from registered state:
  - bolt_retract = (state==OPENING)
  - bolt_extend = (state==CLOSING)
  - locked = (state==LOCKED)
  - bolt_retract and bolt_extend are never both 1.
- State encoding: LOCKED=0, OPENING=1, HOLD=2, CLOSING=3.
- LOCKED:
  - req=1 -> OPENING, cnt <= MOTOR_CYCLES−1.
  - Otherwise stay.
- OPENING:
  - cnt!=0 -> cnt−1.
  - cnt==0 -> HOLD, cnt <= HOLD_CYCLES−1.
  - bolt_retract is therefore high for exactly MOTOR_CYCLES cycles.
- HOLD:
  - door_closed==0 -> cnt reloads to HOLD_CYCLES−1 every such cycle.
  - Otherwise cnt decrements.
  - Exit to CLOSING (cnt <= MOTOR_CYCLES−1) only when cnt==0 and door_closed==1.
  - With the door shut throughout, HOLD lasts exactly HOLD_CYCLES cycles.
- CLOSING:
  - door_closed==0 in any cycle -> abort to OPENING (cnt <= MOTOR_CYCLES−1) for a full re-retract.
  - Otherwise cnt decrements; cnt==0 -> LOCKED.
- req in OPENING, HOLD or CLOSING is ignored. It is not queued, because unlocked is edge-detected.
- A req in the same cycle the FSM returns to LOCKED is also ignored. A new rising edge is required.
- Ajar counter:
  - In HOLD with door_closed==0: ajar_cnt increments, saturating at AJAR_CYCLES.
  - Otherwise ajar_cnt clears.
  - ajar_alarm <= (state==HOLD && door_closed==0 && ajar_cnt==AJAR_CYCLES−1) or (ajar_alarm && state==HOLD && door_closed==0).
  - Net effect: the alarm rises on the AJAR_CYCLES-th consecutive open cycle and clears the cycle after the door closes.
- Counters never wrap: decrement is only applied when cnt!=0.

Test Plan:
Params MOTOR_CYCLES=4, HOLD_CYCLES=6, AJAR_CYCLES=5.
1. Reset, then unlocked 0->1 with door_closed=1 held:
   - bolt_retract high 4 cycles, then 6 cycles HOLD, then bolt_extend high 4 cycles.
   - locked=0 for all 14 cycles, then locked=1.
2. unlocked held high across the whole sequence, then retoggled 1->0->1:
   - No second cycle starts until the new rising edge; that edge starts exactly one new sequence.
3. door_closed=0 for 8 cycles starting at HOLD cycle 2:
   - ajar_alarm rises on open cycle 5 and clears 1 cycle after door_closed=1.
   - HOLD then lasts 6 more cycles before CLOSING.
4. door_closed drops at CLOSING cycle 2:
   - Next cycle bolt_extend=0, bolt_retract=1 for 4 cycles; returns to HOLD with the full 6-cycle timer.
5. reset=0 for 1 cycle during OPENING:
   - Next edge state_dbg=0, locked=1, motor outputs 0, alarm 0.
   - A subsequent unlock works normally.
6. closer pulse 1,0,1 over 3 cycles in any state:
   - near_led follows with 1-cycle delay.
   - Motor outputs and state are unaffected.
